// File: rtl/lz77_encoder.sv
// LZ77 streaming encoder: 9-entry search window, 8-entry look-ahead buffer.
// Emits one (code_pos, code_len, chardata) token per match; the input string ends with '$'.
// Optional feature: define LZ77_ENC_OVERLAP_EN to let a match run past sb[0] into the
// look-ahead buffer. When undefined, matches are limited to window characters only.
module lz77_encoder (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       code_valid,
    output logic [3:0] code_pos,
    output logic [2:0] code_len,
    output logic [7:0] chardata,
    output logic       finish
);
    localparam int unsigned SB_DEPTH = 9;
    localparam int unsigned LA_DEPTH = 8;
    localparam logic [7:0]  EOS_CHAR = 8'h24;

    localparam logic [2:0] S_FILL   = 3'd0;
    localparam logic [2:0] S_SEARCH = 3'd1;
    localparam logic [2:0] S_EMIT   = 3'd2;
    localparam logic [2:0] S_SHIFT  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0] state, state_n;
    logic [7:0] sb   [SB_DEPTH];
    logic [7:0] sb_n [SB_DEPTH];
    logic [7:0] la   [LA_DEPTH];
    logic [7:0] la_n [LA_DEPTH];
    logic [3:0] sb_cnt, sb_cnt_n;
    logic [3:0] la_cnt, la_cnt_n;
    logic       eos, eos_n;
    logic [3:0] cand_pos, cand_pos_n;
    logic [2:0] best_len, best_len_n;
    logic [3:0] best_pos, best_pos_n;
    logic [2:0] shift_cnt, shift_cnt_n;

    logic       in_ready_n;
    logic       code_valid_n;
    logic [3:0] code_pos_n;
    logic [2:0] code_len_n;
    logic [7:0] chardata_n;
    logic       finish_n;

    logic [2:0] cap;
    logic [2:0] cand_len;
    logic       run;
    logic       in_window;
    logic [7:0] src;

    // Match length of candidate distance cand_pos against the look-ahead buffer
    always_comb begin
        cap       = (la_cnt >= 4'(LA_DEPTH)) ? 3'(LA_DEPTH - 1) : 3'(la_cnt - 4'd1);
        run       = 1'b1;
        cand_len  = '0;
        src       = '0;
        in_window = 1'b1;
        for (int k = 0; k < int'(LA_DEPTH) - 1; k++) begin
            if (k <= int'(cand_pos)) begin
                src = sb[4'(int'(cand_pos) - k)];
            end else begin
                src = la[3'(k - int'(cand_pos) - 1)];
            end
`ifdef LZ77_ENC_OVERLAP_EN
            in_window = 1'b1;
`else
            in_window = (k <= int'(cand_pos));
`endif
            if (run && in_window && (3'(k) < cap) && (la[3'(k)] == src)) begin
                cand_len = cand_len + 3'd1;
            end else begin
                run = 1'b0;
            end
        end
    end

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_n      = state;
        sb_n         = sb;
        la_n         = la;
        sb_cnt_n     = sb_cnt;
        la_cnt_n     = la_cnt;
        eos_n        = eos;
        cand_pos_n   = cand_pos;
        best_len_n   = best_len;
        best_pos_n   = best_pos;
        shift_cnt_n  = shift_cnt;
        code_valid_n = 1'b0;
        code_pos_n   = code_pos;
        code_len_n   = code_len;
        chardata_n   = chardata;
        finish_n     = finish;
        in_ready_n   = 1'b0;

        case (state)
            S_FILL: begin
                if (in_valid && (la_cnt < 4'(LA_DEPTH)) && !eos) begin
                    la_n[la_cnt[2:0]] = in_data;
                    la_cnt_n          = la_cnt + 4'd1;
                    if (in_data == EOS_CHAR) begin
                        eos_n = 1'b1;
                    end
                end
                if ((la_cnt_n == 4'(LA_DEPTH)) || (eos_n && (la_cnt_n != 4'd0))) begin
                    state_n    = S_SEARCH;
                    cand_pos_n = '0;
                    best_len_n = '0;
                    best_pos_n = '0;
                end
            end
            S_SEARCH: begin
                if ((cand_pos < sb_cnt) && (cand_len > best_len)) begin
                    best_len_n = cand_len;
                    best_pos_n = cand_pos;
                end
                if (cand_pos == 4'(SB_DEPTH - 1)) begin
                    // Last candidate: load the token so code_valid is high in the EMIT cycle
                    state_n      = S_EMIT;
                    cand_pos_n   = '0;
                    code_valid_n = 1'b1;
                    code_len_n   = best_len_n;
                    code_pos_n   = (best_len_n == 3'd0) ? 4'd0 : best_pos_n;
                    chardata_n   = la[best_len_n];
                end else begin
                    cand_pos_n = cand_pos + 4'd1;
                end
            end
            S_EMIT: begin
                state_n     = S_SHIFT;
                shift_cnt_n = '0;
            end
            S_SHIFT: begin
                sb_n[0] = la[0];
                for (int i = 1; i < int'(SB_DEPTH); i++) begin
                    sb_n[i] = sb[i - 1];
                end
                for (int i = 0; i < int'(LA_DEPTH) - 1; i++) begin
                    la_n[i] = la[i + 1];
                end
                la_n[LA_DEPTH - 1] = '0;
                sb_cnt_n    = (sb_cnt == 4'(SB_DEPTH)) ? sb_cnt : sb_cnt + 4'd1;
                la_cnt_n    = la_cnt - 4'd1;
                shift_cnt_n = shift_cnt + 3'd1;
                if (shift_cnt == code_len) begin
                    if (chardata == EOS_CHAR) begin
                        state_n  = S_DONE;
                        finish_n = 1'b1;
                    end else begin
                        state_n = S_FILL;
                    end
                end
            end
            S_DONE: begin
                state_n = S_DONE;
            end
            default: begin
                state_n = S_FILL;
            end
        endcase

        // in_ready mirrors the FILL-state acceptance condition of the next cycle
        in_ready_n = (state_n == S_FILL) && (la_cnt_n < 4'(LA_DEPTH)) && !eos_n;
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_FILL;
            sb         <= '{default: '0};
            la         <= '{default: '0};
            sb_cnt     <= '0;
            la_cnt     <= '0;
            eos        <= 1'b0;
            cand_pos   <= '0;
            best_len   <= '0;
            best_pos   <= '0;
            shift_cnt  <= '0;
            in_ready   <= 1'b0;
            code_valid <= 1'b0;
            code_pos   <= '0;
            code_len   <= '0;
            chardata   <= '0;
            finish     <= 1'b0;
        end else begin
            state      <= state_n;
            sb         <= sb_n;
            la         <= la_n;
            sb_cnt     <= sb_cnt_n;
            la_cnt     <= la_cnt_n;
            eos        <= eos_n;
            cand_pos   <= cand_pos_n;
            best_len   <= best_len_n;
            best_pos   <= best_pos_n;
            shift_cnt  <= shift_cnt_n;
            in_ready   <= in_ready_n;
            code_valid <= code_valid_n;
            code_pos   <= code_pos_n;
            code_len   <= code_len_n;
            chardata   <= chardata_n;
            finish     <= finish_n;
        end
    end

endmodule

// File: tb/tb_lz77_encoder.sv
// Bench for lz77_encoder: directed and random strings against a flat-string LZ77 model.
// Honours LZ77_ENC_OVERLAP_EN the same way the design does.
module tb_lz77_encoder;
    typedef struct packed {
        logic [3:0] pos;
        logic [2:0] len;
        logic [7:0] ch;
    } tok_t;

    logic       clk;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       code_valid;
    logic [3:0] code_pos;
    logic [2:0] code_len;
    logic [7:0] chardata;
    logic       finish;

    int   checks;
    int   errors;
    int   cyc;
    int   last_acc;
    bit   acc_since;
    tok_t got_q[$];

    lz77_encoder dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .code_valid (code_valid),
        .code_pos   (code_pos),
        .code_len   (code_len),
        .chardata   (chardata),
        .finish     (finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter for latency checks
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Token capture plus accept-to-token latency
    always @(negedge clk) begin
        tok_t t;
        if (!reset) begin
            if (in_valid && in_ready) begin
                last_acc  = cyc;
                acc_since = 1'b1;
            end
            if (code_valid) begin
                t.pos = code_pos;
                t.len = code_len;
                t.ch  = chardata;
                got_q.push_back(t);
                if (acc_since) check("latency", 32'(cyc - last_acc), 32'd10);
                acc_since = 1'b0;
            end
        end
    end

    // Reference: greedy LZ77 over the flat input string
    task automatic model(input byte s[$], output tok_t q[$]);
        int i, n, cap, win, bl, bd, l, lim;
        tok_t t;
        q.delete();
        n = s.size();
        i = 0;
        while (i < n) begin
            cap = (n - i - 1 < 7) ? n - i - 1 : 7;
            win = (i < 9) ? i : 9;
            bl  = 0;
            bd  = 0;
            for (int d = 0; d < win; d++) begin
                lim = cap;
`ifndef LZ77_ENC_OVERLAP_EN
                if (lim > d + 1) lim = d + 1;
`endif
                l = 0;
                while (l < lim && s[i + l] == s[i - 1 - d + l]) l++;
                if (l > bl) begin
                    bl = l;
                    bd = d;
                end
            end
            t.pos = (bl == 0) ? 4'd0 : 4'(bd);
            t.len = 3'(bl);
            t.ch  = s[i + bl];
            q.push_back(t);
            i += bl + 1;
        end
    endtask

    task automatic str_q(input string s, output byte q[$]);
        q.delete();
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_code_valid"}, code_valid, 0);
        check({tag, "_code_pos"}, code_pos, 0);
        check({tag, "_code_len"}, code_len, 0);
        check({tag, "_chardata"}, chardata, 0);
        check({tag, "_finish"}, finish, 0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset     = 1'b0;
        got_q.delete();
        acc_since = 1'b0;
        @(negedge clk);
        check("post_rst_ready", in_ready, 1);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        check_zero("rst");
        repeat (2) @(negedge clk);
        release_reset();
    endtask

    // Offer characters with random idle gaps; junk is held valid afterwards
    task automatic send(input byte s[$], input int gap_pct);
        int i;
        int budget;
        i = 0;
        budget = 0;
        while (i < s.size() && budget < 2000) begin
            @(posedge clk);
            #1;
            budget++;
            if ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = s[i];
            end
            @(negedge clk);
            if (in_valid && in_ready) i++;
        end
        check("send_all", i, s.size());
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 8'h71;
    endtask

    task automatic finish_and_compare(input string name, input byte s[$]);
        tok_t exp_q[$];
        byte  out[$];
        int   bad;
        int   p;
        model(s, exp_q);
        for (int w = 0; w < 3000 && !finish; w++) @(negedge clk);
        check({name, "_finish"}, finish, 1);
        repeat (15) @(negedge clk);
        check({name, "_ready_done"}, in_ready, 0);
        check({name, "_finish_held"}, finish, 1);
        check({name, "_ntok"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s_t%0d_pos", name, i), got_q[i].pos, exp_q[i].pos);
            check($sformatf("%s_t%0d_len", name, i), got_q[i].len, exp_q[i].len);
            check($sformatf("%s_t%0d_ch", name, i), got_q[i].ch, exp_q[i].ch);
        end
        // Decoder replay of the captured tokens
        bad = 0;
        out.delete();
        foreach (got_q[i]) begin
            p = int'(got_q[i].pos);
            for (int k = 0; k < int'(got_q[i].len); k++) begin
                if (out.size() > p) out.push_back(out[out.size() - 1 - p]);
                else begin
                    bad++;
                    out.push_back(8'h00);
                end
            end
            out.push_back(got_q[i].ch);
        end
        check({name, "_replay_len"}, out.size(), s.size());
        for (int i = 0; i < out.size() && i < s.size(); i++) if (out[i] != s[i]) bad++;
        check({name, "_replay_bad"}, bad, 0);
    endtask

    task automatic run_case(input string name, input byte s[$], input int gap);
        apply_reset();
        send(s, gap);
        finish_and_compare(name, s);
    endtask

    initial begin
        byte q[$];
        int  n;
        checks    = 0;
        errors    = 0;
        last_acc  = 0;
        acc_since = 1'b0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;

        str_q("$", q);            run_case("eos", q, 0);
        str_q("aaaa$", q);        run_case("aaaa", q, 0);
        str_q("abcabcabc$", q);   run_case("abc3", q, 0);
        str_q("abcdefghija$", q); run_case("wrap", q, 0);
        str_q("abxab$", q);       run_case("gaps", q, 50);

        // Reset in the middle of a search, then a fresh string with no history
        apply_reset();
        str_q("abab$", q);
        send(q, 0);
        for (int w = 0; w < 200 && got_q.size() < 2; w++) @(negedge clk);
        check("midrst_pre_tokens", got_q.size(), 2);
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_zero("midrst");
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        release_reset();
        str_q("ab$", q);
        send(q, 20);
        finish_and_compare("after_rst", q);

        // Random strings over a small alphabet to provoke matches
        for (int r = 0; r < 6; r++) begin
            q.delete();
            n = $urandom_range(1, 18);
            for (int i = 0; i < n; i++) q.push_back(8'(8'h61 + $urandom_range(0, 2)));
            q.push_back(8'h24);
            run_case($sformatf("rnd%0d", r), q, 30);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
